// File: rtl/kbest_pkg.sv
// rtl/kbest_pkg.sv - shared types and constants for the k-best result reader
// Optional ping-pong prefetch is selected by KBEST_RD_PREFETCH_EN.
package kbest_pkg;
    localparam int KBEST_ADDR_W = 8;
    localparam int KBEST_DEPTH  = 2 ** KBEST_ADDR_W;
    localparam int KBEST_DATA_W = 32;
    localparam int KBEST_K      = 4;

`ifdef KBEST_RD_PREFETCH_EN
    localparam int KBEST_NBUF = 2;
`else
    localparam int KBEST_NBUF = 1;
`endif

    typedef enum logic [2:0] {IDLE, RD, CAP, SEND, FIN} rd_state_t;
    typedef logic [KBEST_DATA_W-1:0] kbest_word_t;
endpackage

// File: rtl/kbest_array_reader_if.sv
// rtl/kbest_array_reader_if.sv - output word stream of the k-best array reader
interface kbest_array_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int ADDR_WIDTH = 8
);
    localparam int BANK_W = (K > 1) ? $clog2(K) : 1;

    logic [DATA_WIDTH-1:0] out_data;
    logic [BANK_W-1:0]     out_bank;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (output out_data, out_bank, out_addr, out_valid, out_last, input out_ready);
    modport slave  (input out_data, out_bank, out_addr, out_valid, out_last, output out_ready);
endinterface

// File: rtl/kbest_rd_serializer.sv
// rtl/kbest_rd_serializer.sv - K-word hold buffer(s) and bank counter feeding the output stream
// Two buffers are used as a ping-pong pair when KBEST_RD_PREFETCH_EN is defined.
module kbest_rd_serializer
    import kbest_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int K          = 4,
    parameter int ADDR_WIDTH = 8,
    parameter int BANK_W     = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_cap,
    input  logic [K-1:0][DATA_WIDTH-1:0]   i_cap_data,
    input  logic [ADDR_WIDTH-1:0]          i_cap_addr,
    input  logic                           i_cap_last,
    input  logic                           i_ready,
    output logic [DATA_WIDTH-1:0]          o_data,
    output logic [BANK_W-1:0]              o_bank,
    output logic [ADDR_WIDTH-1:0]          o_addr,
    output logic                           o_valid,
    output logic                           o_last,
    output logic                           o_word_done,
    output logic [1:0]                     o_occupancy
);
    // With a single buffer the pointers never toggle and buffer 1 is never written.
    localparam logic PP = (KBEST_NBUF == 2);

    logic [K-1:0][DATA_WIDTH-1:0] r_buf  [2];
    logic [ADDR_WIDTH-1:0]        r_addr [2];
    logic [1:0]                   r_lastf;
    logic [1:0]                   r_full;
    logic                         r_wp;
    logic                         r_rp;
    logic [BANK_W-1:0]            r_bank;

    logic w_hs;
    logic w_bank_end;

    assign w_bank_end  = (r_bank == BANK_W'(K - 1));
    assign o_valid     = r_full[r_rp];
    assign w_hs        = o_valid & i_ready;
    assign o_word_done = w_hs & w_bank_end;
    assign o_data      = r_buf[r_rp][r_bank];
    assign o_bank      = r_bank;
    assign o_addr      = r_addr[r_rp];
    assign o_last      = r_lastf[r_rp] & w_bank_end;
    assign o_occupancy = {1'b0, r_full[0]} + {1'b0, r_full[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf[0]  <= '0;
            r_buf[1]  <= '0;
            r_addr[0] <= '0;
            r_addr[1] <= '0;
            r_lastf   <= '0;
            r_full    <= '0;
            r_wp      <= 1'b0;
            r_rp      <= 1'b0;
            r_bank    <= '0;
        end else begin
            if (i_cap) begin
                r_buf[r_wp]   <= i_cap_data;
                r_addr[r_wp]  <= i_cap_addr;
                r_lastf[r_wp] <= i_cap_last;
                r_full[r_wp]  <= 1'b1;
                r_wp          <= r_wp ^ PP;
            end
            if (w_hs) begin
                if (w_bank_end) begin
                    r_bank       <= '0;
                    r_full[r_rp] <= 1'b0;
                    r_rp         <= r_rp ^ PP;
                end else begin
                    r_bank <= r_bank + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/kbest_array_reader.sv
// rtl/kbest_array_reader.sv - walks an address range on SRAM read port 1 and streams all K bank words
// KBEST_RD_PREFETCH_EN (see kbest_pkg) overlaps the next read with streaming of the current one.
module kbest_array_reader
    import kbest_pkg::*;
#(
    parameter int DATA_WIDTH = KBEST_DATA_W,
    parameter int K          = KBEST_K,
    parameter int ADDR_WIDTH = KBEST_ADDR_W
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [ADDR_WIDTH-1:0]        start_addr,
    input  logic [ADDR_WIDTH:0]          num_addrs,
    output logic                         busy,
    output logic                         done,
    output logic [K-1:0]                 csb1,
    output logic [ADDR_WIDTH-1:0]        addr1,
    input  logic [K-1:0][DATA_WIDTH-1:0] rdata1,
    kbest_array_reader_if.master         out_if
);
    localparam int BANK_W = (K > 1) ? $clog2(K) : 1;

    rd_state_t             r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_iss_addr;
    logic [ADDR_WIDTH:0]   r_iss_left;
    logic [ADDR_WIDTH:0]   r_remaining;
    logic [ADDR_WIDTH-1:0] r_cap_addr;
    logic                  r_cap_last;
    logic                  r_cap_pend;
    logic                  w_issue;
    logic                  w_word_done;
    logic [1:0]            w_occ;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // A read may issue in SEND only when a hold buffer is free even after the pending capture.
    always_comb begin
        w_next  = r_state;
        w_issue = 1'b0;
        busy    = 1'b1;
        done    = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) w_next = (num_addrs == '0) ? FIN : RD;
            end
            RD: begin
                w_issue = 1'b1;
                w_next  = CAP;
            end
            CAP: w_next = SEND;
            SEND: begin
                w_issue = (r_iss_left != '0) &&
                          (({1'b0, w_occ} + {2'b0, r_cap_pend}) < 3'(KBEST_NBUF));
                if (w_word_done) begin
                    if (r_remaining == (ADDR_WIDTH+1)'(1)) w_next = FIN;
                    else                                   w_next = (KBEST_NBUF == 2) ? SEND : RD;
                end
            end
            FIN: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    assign csb1  = w_issue ? '0 : '1;
    assign addr1 = r_iss_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_addr  <= '0;
            r_iss_left  <= '0;
            r_remaining <= '0;
            r_cap_addr  <= '0;
            r_cap_last  <= 1'b0;
            r_cap_pend  <= 1'b0;
        end else begin
            r_cap_pend <= w_issue;
            if (r_state == IDLE && start) begin
                r_iss_addr  <= start_addr;
                r_iss_left  <= num_addrs;
                r_remaining <= num_addrs;
            end
            if (w_issue) begin
                r_cap_addr <= r_iss_addr;
                r_cap_last <= (r_iss_left == (ADDR_WIDTH+1)'(1));
                r_iss_addr <= r_iss_addr + 1'b1;
                r_iss_left <= r_iss_left - 1'b1;
            end
            if (w_word_done) r_remaining <= r_remaining - 1'b1;
        end
    end

    kbest_rd_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .K          (K),
        .ADDR_WIDTH (ADDR_WIDTH),
        .BANK_W     (BANK_W)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cap       (r_cap_pend),
        .i_cap_data  (rdata1),
        .i_cap_addr  (r_cap_addr),
        .i_cap_last  (r_cap_last),
        .i_ready     (out_if.out_ready),
        .o_data      (out_if.out_data),
        .o_bank      (out_if.out_bank),
        .o_addr      (out_if.out_addr),
        .o_valid     (out_if.out_valid),
        .o_last      (out_if.out_last),
        .o_word_done (w_word_done),
        .o_occupancy (w_occ)
    );
endmodule
